// File: rtl/adder_pipe_ctrl.sv
// ============================================================================
// Module   : adder_pipe_ctrl
// Purpose  : Valid/ready sequencer driving halt/refresh of a stallable pipeline
//            adder. Optional performance counters under ADDER_PIPE_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_pipe_ctrl #(
    parameter int STAGES = 4,
    parameter int OCC_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    input  logic              ext_stall_i,
    input  logic              flush_req_i,
    input  logic [STAGES-1:0] flush_mask_i,
    output logic [STAGES-1:0] halt_o,
    output logic [STAGES-1:0] refresh_o,
    output logic [OCC_W-1:0]  occupancy_o,
    output logic              idle_o,
    output logic [31:0]       perf_ops_o,
    output logic [31:0]       perf_stalls_o
);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] w_kill;
    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_halt;
    logic              w_in_fire;
    logic [OCC_W-1:0]  w_occ;

    assign w_kill = flush_mask_i & {STAGES{flush_req_i}};

    // A stage only holds when every stage downstream of it is also blocked.
    always_comb begin
        logic h;
        w_hold = '0;
        h      = v_q[STAGES-1] & ~out_ready_i;
        w_hold[STAGES-1] = h;
        for (int i = STAGES - 2; i >= 0; i--) begin
            h         = v_q[i] & h;
            w_hold[i] = h;
        end
    end

    assign w_halt = ({STAGES{ext_stall_i}} | w_hold) & ~w_kill;

    // Refresh is forced during reset so the adder's own registers clear too.
    assign halt_o      = rst_n ? w_halt : '0;
    assign refresh_o   = rst_n ? w_kill : '1;
    assign in_ready_o  = rst_n & ~ext_stall_i & ~w_hold[0] & ~w_kill[0];
    assign out_valid_o = v_q[STAGES-1] & ~ext_stall_i & ~w_kill[STAGES-1];
    assign w_in_fire   = in_valid_i & in_ready_o;

    always_comb begin
        v_d = v_q;
        for (int i = 0; i < STAGES; i++) begin
            if (w_kill[i]) begin
                v_d[i] = 1'b0;
            end else if (w_halt[i]) begin
                v_d[i] = v_q[i];
            end else if (i == 0) begin
                v_d[i] = w_in_fire;
            end else begin
                v_d[i] = v_q[i-1] & ~w_kill[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_occ = w_occ + OCC_W'(v_q[i]);
        end
    end

    assign occupancy_o = w_occ;
    assign idle_o      = (v_q == '0);

`ifdef ADDER_PIPE_CTRL_PERF_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_stalls_q;
    logic        w_out_fire;
    logic        w_stall_cyc;

    assign w_out_fire  = out_valid_o & out_ready_i;
    assign w_stall_cyc = v_q[STAGES-1] & ~out_ready_i & ~ext_stall_i & ~w_kill[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q    <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (w_out_fire) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if (w_stall_cyc) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_ops_o    = perf_ops_q;
    assign perf_stalls_o = perf_stalls_q;
`else
    assign perf_ops_o    = '0;
    assign perf_stalls_o = '0;
`endif

endmodule

`default_nettype wire
